// File: rtl/mux_pkg.sv
// Shared constants and types for the 1:4 TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds a fifth, even-parity slot to each frame.
package mux_pkg;

  localparam int NUM_CH = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = NUM_CH + 1;
`else
  localparam int FRAME_LEN = NUM_CH;
`endif

  localparam int SW = (FRAME_LEN > 4) ? 3 : 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic [SW-1:0] slot_inc(
    input logic [SW-1:0] s
  );
    if (s == SW'(FRAME_LEN - 1))
      slot_inc = '0;
    else
      slot_inc = s + 1'b1;
  endfunction

endpackage

// File: rtl/dec_2_4.sv
// Slot index to one-hot shadow write enable.
// Only channel slots reach this decoder; en gates the whole output.
module dec_2_4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] oh
);

  always_comb begin
    oh = '0;
    if (en) begin
      unique case (sel)
        2'd0: oh = 4'b0001;
        2'd1: oh = 4'b0010;
        2'd2: oh = 4'b0100;
        2'd3: oh = 4'b1000;
        default: oh = '0;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux_1_4.sv
// Serial TDM stream to 4-channel registered parallel frame.
// Define TDM_DEMUX_PARITY_EN for a 5-slot frame with parity check.
module tdm_demux_1_4
  import mux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              valid,
  input  logic              sync,
  output logic [4*W-1:0]    Y,
  output logic [SW-1:0]     S,
  output logic              locked,
  output logic              frame_done,
  output logic              sync_err,
  output logic              parity_err
);

  state_e state_q, state_d;

  logic [SW-1:0]     slot_q, slot_d;
  logic [W-1:0]      shadow_q [NUM_CH];
  logic [W-1:0]      shadow_d [NUM_CH];
  logic [4*W-1:0]    y_q, y_d;
  logic              fd_q, fd_d;
  logic              se_q, se_d;
  logic              pe_q, pe_d;

  logic              acc;
  logic              resync;
  logic [SW-1:0]     wr_slot;
  logic              wr_en;
  logic [NUM_CH-1:0] we;
  logic [4*W-1:0]    fr;
  logic              commit;
`ifdef TDM_DEMUX_PARITY_EN
  logic [W-1:0]      par;
  logic              last;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= HUNT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (valid && sync) state_d = LOCKED;
      LOCKED:  state_d = LOCKED;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  // A valid sync always restarts the frame at slot 0
  always_comb begin
    acc     = valid & (sync | (state_q == LOCKED));
    resync  = valid & sync;
    wr_slot = resync ? '0 : slot_q;
    slot_d  = acc ? slot_inc(wr_slot) : slot_q;
`ifdef TDM_DEMUX_PARITY_EN
    wr_en   = acc & (wr_slot != 3'd4);
`else
    wr_en   = acc;
`endif
  end

  dec_2_4 u_dec (
    .sel (wr_slot[1:0]),
    .en  (wr_en),
    .oh  (we)
  );

  always_comb begin
    fr = '0;
    for (int k = 0; k < NUM_CH - 1; k++)
      fr[k*W +: W] = shadow_q[k];
`ifdef TDM_DEMUX_PARITY_EN
    fr[(NUM_CH-1)*W +: W] = shadow_q[NUM_CH-1];
    par = '0;
    for (int k = 0; k < NUM_CH; k++)
      par = par ^ shadow_q[k];
    last   = acc & (wr_slot == 3'd4);
    commit = last & (din == par);
    pe_d   = last & (din != par);
`else
    // Slot 3 bypasses the shadow so Y lands on the same edge
    fr[(NUM_CH-1)*W +: W] = din;
    commit = acc & (wr_slot == 2'd3);
    pe_d   = 1'b0;
`endif
    se_d = resync & (state_q == LOCKED) & (slot_q != '0);
    fd_d = commit;
    y_d  = commit ? fr : y_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (we[k])
        shadow_d[k] = din;
      else if (resync && k != 0)
        shadow_d[k] = '0;
      else
        shadow_d[k] = shadow_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      shadow_q <= '{default: '0};
      y_q      <= '0;
      fd_q     <= 1'b0;
      se_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fd_q     <= fd_d;
      se_q     <= se_d;
      pe_q     <= pe_d;
    end
  end

  assign Y          = y_q;
  assign S          = slot_q;
  assign frame_done = fd_q;
  assign sync_err   = se_q;
  assign parity_err = pe_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4 with W=1.
// Parity cases run when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1_4;
  import mux_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:0]    din;
  logic          valid;
  logic          sync;
  logic [3:0]    Y;
  logic [SW-1:0] S;
  logic          locked;
  logic          frame_done;
  logic          sync_err;
  logic          parity_err;

  int n_chk  = 0;
  int n_fail = 0;

  tdm_demux_1_4 #(.W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .valid      (valid),
    .sync       (sync),
    .Y          (Y),
    .S          (S),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic snd(input logic d, input logic v, input logic s);
    din   = d;
    valid = v;
    sync  = s;
    @(posedge clk);
    #1;
    din   = 1'b0;
    valid = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frm(input logic [3:0] d);
    snd(d[0], 1'b1, 1'b1);
    for (int i = 1; i < 4; i++)
      snd(d[i], 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    snd(^d, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    logic [3:0] pat;
    pat   = 4'b1011;
    rst   = 1'b1;
    din   = 1'b0;
    valid = 1'b0;
    sync  = 1'b0;
    idle(2);
    check("rst_Y", Y, 0);
    check("rst_S", S, 0);
    check("rst_lock", locked, 0);
    check("rst_fd", frame_done, 0);
    check("rst_se", sync_err, 0);
    check("rst_pe", parity_err, 0);
    rst = 1'b0;

    // No sync: stay hunting
    for (int i = 0; i < 4; i++) begin
      snd(pat[i], 1'b1, 1'b0);
      check("hunt_lock", locked, 0);
      check("hunt_Y", Y, 0);
      check("hunt_fd", frame_done, 0);
      check("hunt_S", S, 0);
    end

    // Frame 1,0,1,1
    snd(1'b1, 1'b1, 1'b1);
    check("a0_lock", locked, 1);
    check("a0_S", S, 1);
    check("a0_Y", Y, 0);
    snd(1'b0, 1'b1, 1'b0);
    check("a1_S", S, 2);
    snd(1'b1, 1'b1, 1'b0);
    check("a2_S", S, 3);
    check("a2_Y", Y, 0);
    snd(1'b1, 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    check("a3_S", S, 4);
    check("a3_Y", Y, 0);
    check("a3_fd", frame_done, 0);
    snd(1'b1, 1'b1, 1'b0);
    check("a4_pe", parity_err, 0);
`endif
    check("a_Y", Y, 4'b1101);
    check("a_fd", frame_done, 1);
    check("a_S", S, 0);
    idle(1);
    check("a_fd_off", frame_done, 0);
    check("a_Y_hold", Y, 4'b1101);

    // Sync without valid is ignored
    snd(1'b1, 1'b0, 1'b1);
    check("nv_S", S, 0);
    check("nv_se", sync_err, 0);
    check("nv_lock", locked, 1);

    // Frame 0,1,1,0 with a 3-cycle gap after slot 1
    snd(1'b0, 1'b1, 1'b1);
    check("b0_se", sync_err, 0);
    check("b0_S", S, 1);
    snd(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("gap_S", S, 2);
      check("gap_Y", Y, 4'b1101);
      check("gap_fd", frame_done, 0);
    end
    snd(1'b1, 1'b1, 1'b0);
    snd(1'b0, 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    snd(1'b0, 1'b1, 1'b0);
`endif
    check("b_Y", Y, 4'b0110);
    check("b_fd", frame_done, 1);

    // Misaligned sync at S=2
    snd(1'b1, 1'b1, 1'b1);
    snd(1'b0, 1'b1, 1'b0);
    check("m_S2", S, 2);
    snd(1'b0, 1'b1, 1'b1);
    check("m_se", sync_err, 1);
    check("m_S", S, 1);
    check("m_Y", Y, 4'b0110);
    check("m_lock", locked, 1);
    idle(1);
    check("m_se_off", sync_err, 0);
    snd(1'b0, 1'b1, 1'b0);
    snd(1'b0, 1'b1, 1'b0);
    snd(1'b1, 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    snd(1'b1, 1'b1, 1'b0);
`endif
    check("m_newY", Y, 4'b1000);
    check("m_fd", frame_done, 1);

    // Reset after slot 1 dominates valid&sync
    snd(1'b1, 1'b1, 1'b1);
    snd(1'b1, 1'b1, 1'b0);
    check("r_S2", S, 2);
    rst   = 1'b1;
    din   = 1'b1;
    valid = 1'b1;
    sync  = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    sync  = 1'b0;
    check("r_Y", Y, 0);
    check("r_S", S, 0);
    check("r_lock", locked, 0);
    check("r_fd", frame_done, 0);
    check("r_se", sync_err, 0);
    for (int i = 0; i < 2; i++) begin
      snd(1'b1, 1'b1, 1'b0);
      check("r_hunt_lock", locked, 0);
      check("r_hunt_S", S, 0);
      check("r_hunt_Y", Y, 0);
    end
    frm(4'b1111);
    check("r_newY", Y, 4'b1111);
    check("r_newfd", frame_done, 1);

`ifdef TDM_DEMUX_PARITY_EN
    // Wrong parity for 0,1,1,0
    snd(1'b0, 1'b1, 1'b1);
    snd(1'b1, 1'b1, 1'b0);
    snd(1'b1, 1'b1, 1'b0);
    snd(1'b0, 1'b1, 1'b0);
    snd(1'b1, 1'b1, 1'b0);
    check("p_pe", parity_err, 1);
    check("p_fd", frame_done, 0);
    check("p_Y", Y, 4'b1111);
    check("p_S", S, 0);
    check("p_lock", locked, 1);
    idle(1);
    check("p_pe_off", parity_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
